// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_reg
// Description : Two-entry skid-buffered pipeline register. The main register
//               drives out_data and the skid register catches the payload
//               accepted while downstream stalls. in_ready and out_valid are
//               decoded from flops only, so no combinational path crosses
//               the stage in either direction.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // The encoding equals the number of held entries.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_accept;
    logic             w_drain;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    assign w_accept = in_valid & in_ready;
    assign w_drain  = out_valid & out_ready;

    // State register; reset outranks everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath load enables; flush discards any transfer.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = c_EMPTY;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_accept) begin
                        w_load_main_in = 1'b1;
                        w_state_nxt    = c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (w_accept && w_drain) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = c_FULL;
                    end else if (w_drain) begin
                        // main keeps its value so out_data holds the last payload
                        w_state_nxt = c_EMPTY;
                    end
                end
                c_FULL: begin
                    // in_ready is low here, so only a drain can happen
                    if (w_drain) begin
                        w_load_main_skid = 1'b1;
                        w_state_nxt      = c_BUSY;
                    end
                end
                default: begin
                    w_state_nxt = c_EMPTY;
                end
            endcase
        end
    end

    // Payload registers; reset and flush both restore RST_VAL.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main <= RST_VAL;
            r_skid <= RST_VAL;
        end else begin
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    // Handshake and status outputs decoded purely from the state flops.
    always_comb begin
        in_ready  = (r_state != c_FULL);
        out_valid = (r_state != c_EMPTY);
        occupancy = r_state;
    end

    assign out_data = r_main;

endmodule
`default_nettype wire

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the payload width in bits (legal values 1 to 128).
REQ-002 SHALL have parameter RST_VAL, default {WIDTH{1'b0}}, the payload value loaded on reset or flush.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1 bit: synchronous pipeline flush, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream payload is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the stage can accept a payload.
REQ-008 SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the payload.
REQ-011 SHALL have port out_data, output, WIDTH bits: the downstream payload.
REQ-012 SHALL have port occupancy, output, 2 bits: the number of held entries, 0 to 2.

Function
REQ-013 SHALL implement a 2-entry skid-buffered pipeline register: a main register feeding out_data and a skid register.
REQ-014 SHALL use three states: EMPTY (occupancy 0), BUSY (occupancy 1, main valid) and FULL (occupancy 2, main and skid valid).
REQ-015 SHALL define an accept as in_valid & in_ready, and a drain as out_valid & out_ready.
REQ-016 SHALL drive in_ready = (state != FULL), decoded from flops only, with no combinational path from out_ready or in_valid.
REQ-017 SHALL drive out_valid = (state != EMPTY) and out_data = main register, both flop-only.
REQ-018 SHALL, in EMPTY: on accept, load main <= in_data and go to BUSY; otherwise hold.
REQ-019 SHALL, in BUSY: on accept & drain, load main <= in_data and stay in BUSY.
REQ-020 SHALL, in BUSY: on accept & !drain, load skid <= in_data and go to FULL.
REQ-021 SHALL, in BUSY: on drain & !accept, go to EMPTY with main unchanged.
REQ-022 SHALL, in FULL: on drain, load main <= skid and go to BUSY; accept cannot occur in FULL.
REQ-023 SHALL preserve payload order strictly (FIFO) and never duplicate or drop a payload outside reset or flush.
REQ-024 SHALL hold out_data and out_valid stable while out_valid & !out_ready.
REQ-025 SHALL have latency of 1 cycle from accept in EMPTY to out_valid high, and sustain throughput of 1 payload per cycle in BUSY with out_ready held high.
REQ-026 SHALL, on flush, go to EMPTY and load main and skid with RST_VAL on the next edge.
REQ-027 SHALL give flush priority over accept and drain in the same cycle; an accept coinciding with flush is discarded.
REQ-028 SHALL retain the last main value on out_data in EMPTY after a normal drain.
REQ-029 SHALL drive occupancy from the state encoding.

Reset
REQ-030 SHALL, on rst high at a clock edge, set state EMPTY, main = skid = RST_VAL, out_valid = 0, in_ready = 1 and occupancy = 0.
REQ-031 SHALL give rst priority over flush, accept and drain, including in the middle of a transfer.

Verification
REQ-032 SHALL cover streaming: with WIDTH=32 and out_ready=1, drive in_data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on consecutive cycles, each 1 cycle after its accept, with in_ready constantly 1.
REQ-033 SHALL cover backpressure: accept 0xA then 0xB with out_ready=0 -> occupancy 2, in_ready=0, out_data 0xA held; then raise out_ready -> 0xA, then 0xB, with occupancy going 2, 1, 0.
REQ-034 SHALL cover a FULL stall: hold in_valid=1 with 0xC while FULL -> 0xC is not accepted until the cycle after the first drain, and no payload is lost.
REQ-035 SHALL cover flush: in FULL, assert flush together with in_valid and 0xD -> next cycle occupancy 0, out_valid 0, out_data = RST_VAL, and 0xD is never output.
REQ-036 SHALL cover reset mid-operation: assert rst and flush together in BUSY with RST_VAL=0xDEADBEEF -> next cycle EMPTY, out_data 0xDEADBEEF, in_ready 1.
REQ-037 SHALL cover random stress: random in_valid and out_ready over 10,000 cycles with a scoreboard -> in-order, lossless delivery, occupancy never 3, and out_data stable under stall.
